// File: rtl/traffic_phase_scheduler.sv
// Actuated phase sequencer: GREEN_A/YEL_A/GREEN_B/YEL_B/WALK/CLEAR driven by a tick enable.
// Define TLC_PED_REQUEST_EN to serve WALK/CLEAR only after a latched pedestrian request.
module traffic_phase_scheduler #(
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned T_MIN_GREEN = 10,
  parameter int unsigned T_MAX_GREEN = 20,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_WALK      = 15,
  parameter int unsigned T_CLEAR     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             det_a,
  input  logic             det_b,
  input  logic             ped_btn,
  output logic [2:0]       phase,
  output logic             phase_start,
  output logic             ped_wait,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    GreenA = 3'd0,
    YelA   = 3'd1,
    GreenB = 3'd2,
    YelB   = 3'd3,
    Walk   = 3'd4,
    Clear  = 3'd5
  } phase_e;

`ifdef TLC_PED_REQUEST_EN
  localparam bit PedEn = 1'b1;
`else
  localparam bit PedEn = 1'b0;
`endif

  // Count value on the last tick of each phase.
  localparam logic [CNT_W-1:0] MinLast   = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MaxLast   = CNT_W'(T_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YelLast   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] WalkLast  = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] ClearLast = CNT_W'(T_CLEAR - 1);

  phase_e           phase_q, phase_nxt;
  logic [CNT_W-1:0] count_q;
  logic             start_q;
  logic             wait_q;
  logic             phase_end;
  logic             illegal;

  // Codes 6 and 7 both have the top two bits set.
  assign illegal = phase_q[2] & phase_q[1];

  always_comb begin
    phase_end = 1'b0;
    phase_nxt = GreenA;
    case (phase_q)
      GreenA: begin
        phase_end = (count_q == MaxLast) ||
                    ((count_q >= MinLast) && (det_b || wait_q) && !det_a);
        phase_nxt = YelA;
      end
      YelA: begin
        phase_end = (count_q == YelLast);
        phase_nxt = GreenB;
      end
      GreenB: begin
        phase_end = (count_q == MaxLast) ||
                    ((count_q >= MinLast) && (det_a || wait_q) && !det_b);
        phase_nxt = YelB;
      end
      YelB: begin
        phase_end = (count_q == YelLast);
        phase_nxt = (wait_q || !PedEn) ? Walk : GreenA;
      end
      Walk: begin
        phase_end = (count_q == WalkLast);
        phase_nxt = Clear;
      end
      Clear: begin
        phase_end = (count_q == ClearLast);
        phase_nxt = GreenA;
      end
      default: begin
        phase_end = 1'b1;
        phase_nxt = GreenA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= GreenA;
      count_q <= '0;
      start_q <= 1'b0;
    end else if (illegal || (tick && phase_end)) begin
      phase_q <= phase_nxt;
      count_q <= '0;
      start_q <= 1'b1;
    end else begin
      start_q <= 1'b0;
      if (tick) count_q <= count_q + 1'b1;
    end
  end

`ifdef TLC_PED_REQUEST_EN
  logic btn_q;
  logic enter_walk;

  assign enter_walk = !illegal && tick && phase_end && (phase_nxt == Walk);

  // Clearing on WALK entry takes priority over a coincident button edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q  <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      btn_q <= ped_btn;
      if (enter_walk) begin
        wait_q <= 1'b0;
      end else if (ped_btn && !btn_q && (phase_q != Walk)) begin
        wait_q <= 1'b1;
      end
    end
  end
`else
  logic unused_ped_btn;
  assign unused_ped_btn = ped_btn;
  assign wait_q         = 1'b0;
`endif

  assign phase       = phase_q;
  assign count       = count_q;
  assign phase_start = start_q;
  assign ped_wait    = wait_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: per-cycle comparison against a tick-level behavioural
// model, plus directed phase-length measurements with literal expectations.
module tb_traffic_phase_scheduler;

  localparam int TMinG = 10;
  localparam int TMaxG = 20;
  localparam int TY    = 3;
  localparam int TW    = 15;
  localparam int TC    = 3;
`ifdef TLC_PED_REQUEST_EN
  localparam bit PedEn = 1'b1;
`else
  localparam bit PedEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       det_a = 1'b0;
  logic       det_b = 1'b0;
  logic       ped_btn = 1'b0;
  logic [2:0] phase;
  logic       phase_start;
  logic       ped_wait;
  logic [4:0] count;

  int checks = 0;
  int passes = 0;

  traffic_phase_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .det_a      (det_a),
    .det_b      (det_b),
    .ped_btn    (ped_btn),
    .phase      (phase),
    .phase_start(phase_start),
    .ped_wait   (ped_wait),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: phase number, ticks already served in it, and the pending request flag.
  int m_phase = 0;
  int m_count = 0;
  bit m_start = 1'b0;
  bit m_wait  = 1'b0;
  bit m_prev  = 1'b0;

  // Does the phase finish on the tick that makes 'served' ticks in total?
  function automatic bit m_ends(input int p, input int served, input bit da, input bit db,
                                input bit w);
    case (p)
      0:       return served == TMaxG || (served >= TMinG && (db || w) && !da);
      1, 3:    return served == TY;
      2:       return served == TMaxG || (served >= TMinG && (da || w) && !db);
      4:       return served == TW;
      5:       return served == TC;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int m_next(input int p, input bit w);
    case (p)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return (w || !PedEn) ? 4 : 0;
      4:       return 5;
      default: return 0;
    endcase
  endfunction

  wire m_adv  = tick && m_ends(m_phase, m_count + 1, det_a, det_b, m_wait);
  wire m_rise = PedEn && ped_btn && !m_prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_count <= 0;
      m_start <= 1'b0;
      m_wait  <= 1'b0;
      m_prev  <= 1'b0;
    end else begin
      m_prev <= ped_btn;
      if (m_adv) begin
        m_phase <= m_next(m_phase, m_wait);
        m_count <= 0;
        m_start <= 1'b1;
      end else begin
        m_start <= 1'b0;
        if (tick) m_count <= m_count + 1;
      end
      if (m_adv && m_next(m_phase, m_wait) == 4) m_wait <= 1'b0;
      else if (m_rise && m_phase != 4)           m_wait <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("cyc phase", phase, m_phase);
    check("cyc count", count, m_count);
    check("cyc phase_start", phase_start, m_start);
    check("cyc ped_wait", ped_wait, m_wait);
  end

  // Entered on the first cycle of phase p; counts the cycles it lasts (tick=1 throughout).
  task automatic measure(input string name, input int p, input int len, input int nxt);
    int n = 0;
    while (phase == p && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, " length"}, n, len);
    check({name, " next phase"}, phase, nxt);
    check({name, " start pulse"}, phase_start, 1);
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (phase != p && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("reach phase", phase, p);
  endtask

  task automatic pulse_btn();
    ped_btn = 1'b1;
    @(negedge clk);
    ped_btn = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tick    = 1'($urandom);
      det_a   = 1'($urandom);
      det_b   = 1'($urandom);
      ped_btn = 1'($urandom);
    end
    check("reset phase", phase, 0);
    check("reset count", count, 0);
    check("reset phase_start", phase_start, 0);
    check("reset ped_wait", ped_wait, 0);

    // Steady demand on A only: A holds to max, B yields at min.
    tick = 1'b1; det_a = 1'b1; det_b = 1'b0; ped_btn = 1'b0;
    #1 rst_n = 1'b1;
    measure("green_a max", 0, 20, 1);
    measure("yel_a", 1, 3, 2);
    measure("green_b min", 2, 10, 3);
    measure("yel_b", 3, 3, PedEn ? 0 : 4);
`ifndef TLC_PED_REQUEST_EN
    measure("walk", 4, 15, 5);
    measure("clear", 5, 3, 0);
`endif

    // Demand on B only: GREEN_A ends at minimum.
    det_a = 1'b0; det_b = 1'b1;
    measure("green_a min", 0, 10, 1);

    // No tick: nothing moves regardless of detectors.
    tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      det_a = 1'(i); det_b = 1'(i >> 1);
      @(negedge clk);
    end
    check("gated phase", phase, 1);
    check("gated count", count, 0);

    // Sparse ticks with random detectors.
    for (int i = 0; i < 90; i++) begin
      tick = (i % 3 == 0);
      det_a = 1'($urandom); det_b = 1'($urandom);
      @(negedge clk);
    end
    tick = 1'b1; det_a = 1'b1; det_b = 1'b0;

    // Button during GREEN_A.
    wait_phase(0);
    pulse_btn();
    check("ped_wait after press", ped_wait, PedEn ? 1 : 0);
    wait_phase(4);
    check("ped_wait on walk entry", ped_wait, 0);

`ifdef TLC_PED_REQUEST_EN
    pulse_btn();
    check("walk edge ignored", ped_wait, 0);
    wait_phase(5);
    pulse_btn();
    check("clear edge latched", ped_wait, 1);
    wait_phase(0);
    measure("ped green_a", 0, 20, 1);
    measure("ped yel_a", 1, 3, 2);
    measure("ped green_b", 2, 10, 3);
    measure("ped yel_b", 3, 3, 4);
    measure("ped walk", 4, 15, 5);
    measure("ped clear", 5, 3, 0);
    pulse_btn();
    wait_phase(4);
`endif

    // Asynchronous reset in the middle of WALK, button held through release.
    repeat (5) @(negedge clk);
    check("mid-walk phase", phase, 4);
    ped_btn = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("async reset phase", phase, 0);
    check("async reset count", count, 0);
    check("async reset ped_wait", ped_wait, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("held button edge", ped_wait, PedEn ? 1 : 0);
    check("after reset phase", phase, 0);
    ped_btn = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
